// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared FSM encodings, NOP word and control-vector constants for the hazard controller
package cpu_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd2;
    localparam logic [1:0] ST_HALTED     = 2'd3;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_write;
    } ctrl_t;

    // Field order: pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, ex_mem_write
    localparam ctrl_t CTRL_RUN        = 6'b101001;
    localparam ctrl_t CTRL_RESET      = 6'b000110;
    localparam ctrl_t CTRL_FREEZE     = 6'b000000;
    localparam ctrl_t CTRL_BRANCH     = 6'b111111;
    localparam ctrl_t CTRL_BUBBLE     = 6'b000011;
    localparam ctrl_t CTRL_HALT_ISSUE = 6'b000001;
    localparam ctrl_t CTRL_RESUME     = 6'b101111;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_halt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              mem_busy;
    logic              resume;

    logic              pc_write;
    logic              pc_sel;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_write;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_rd, ex_mem_read, ex_branch_taken, mem_busy, resume,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
               ex_mem_write, state_o, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_rd, ex_mem_read, ex_branch_taken, mem_busy, resume,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
               ex_mem_write, state_o, stall_count
    );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator (register 0 never hazards)
module load_use_detect #(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              hazard
);

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - Mealy stall/flush/halt controller for a 5-stage pipeline
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    ctrl_t            ctrl;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .hazard      (hazard)
    );

    // LOAD_STALL and MEM_WAIT (once memory is ready) behave exactly like RUN and fall back to it.
    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = ST_RUN;
        if (!reset) begin
            ctrl = CTRL_RESET;
        end else if (state == ST_HALTED) begin
            ctrl      = CTRL_BUBBLE;
            state_nxt = ST_HALTED;
            if (bus.resume) begin
                ctrl      = CTRL_RESUME;
                state_nxt = ST_RUN;
            end
        end else if (bus.mem_busy) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = ST_MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (hazard) begin
            ctrl      = CTRL_BUBBLE;
            state_nxt = ST_LOAD_STALL;
        end else if (bus.id_halt) begin
            ctrl      = CTRL_HALT_ISSUE;
            state_nxt = ST_HALTED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!ctrl.pc_write && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.pc_sel       = ctrl.pc_sel;
    assign bus.if_id_write  = ctrl.if_id_write;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_write = ctrl.ex_mem_write;
    assign bus.state_o      = state;
    assign bus.stall_count  = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 3;
    localparam int CNT_W  = 4;

    // {state_o[1:0], pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}
    localparam logic [7:0] E_RESET      = 8'b00_000110;
    localparam logic [7:0] E_RUN        = 8'b00_101001;
    localparam logic [7:0] E_LS_STALL   = 8'b00_000011;
    localparam logic [7:0] E_LS_RUN     = 8'b01_101001;
    localparam logic [7:0] E_BRANCH     = 8'b00_111111;
    localparam logic [7:0] E_FREEZE     = 8'b00_000000;
    localparam logic [7:0] E_WAIT       = 8'b10_000000;
    localparam logic [7:0] E_WAIT_REL   = 8'b10_101001;
    localparam logic [7:0] E_HALT_ISSUE = 8'b00_000001;
    localparam logic [7:0] E_HALTED     = 8'b11_000011;
    localparam logic [7:0] E_RESUME     = 8'b11_101111;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [CNT_W-1:0] exp_cnt;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.id_halt = 1'b0; bus.ex_rd = '0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0; bus.resume = 1'b0;
    endtask

    task automatic check_outputs();
        logic [7:0] obs;
        logic [7:0] e;
        string      t;
        obs = {bus.state_o, bus.pc_write, bus.pc_sel, bus.if_id_write,
               bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_write};
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL scoreboard_empty: observed %b expected an entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total_cnt++;
            assert (obs === e) pass_cnt++;
            else $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic check_cnt(input string tag);
        total_cnt++;
        assert (bus.stall_count === exp_cnt) pass_cnt++;
        else $error("FAIL %s: observed stall_count %0d expected %0d", tag, bus.stall_count, exp_cnt);
    endtask

    // Inputs already applied; sample mid-cycle, then advance one clock and update the counter model.
    task automatic step(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        if (!exp[5] && exp_cnt != {CNT_W{1'b1}})
            exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        exp_cnt   = '0;
        reset     = 1'b0;
        idle_inputs();

        #3;
        exp_q.push_back(E_RESET); tag_q.push_back("reset_outputs");
        check_outputs();
        check_cnt("reset_count");
        @(posedge clk); #1;
        reset = 1'b1;

        step("run_idle", E_RUN);
        check_cnt("run_idle_count");

        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd3; bus.id_rs1 = 3'd3; bus.id_use_rs1 = 1'b1;
        step("load_use_rs1_stall", E_LS_STALL);
        idle_inputs();
        step("load_stall_state", E_LS_RUN);
        step("load_stall_back_run", E_RUN);
        check_cnt("load_use_count");

        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd5; bus.id_rs2 = 3'd5; bus.id_use_rs2 = 1'b1;
        step("load_use_rs2_stall", E_LS_STALL);
        idle_inputs();
        step("load_stall_rs2_state", E_LS_RUN);

        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd4; bus.id_rs1 = 3'd4; bus.id_use_rs1 = 1'b0;
        step("unused_rs1_no_stall", E_RUN);

        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd0; bus.id_rs1 = 3'd0; bus.id_use_rs1 = 1'b1;
        step("rd_zero_no_stall", E_RUN);
        check_cnt("rd_zero_count");

        bus.ex_rd = 3'd3; bus.id_rs1 = 3'd3; bus.ex_branch_taken = 1'b1;
        step("branch_over_load_use", E_BRANCH);
        idle_inputs();
        step("branch_stays_run", E_RUN);

        bus.mem_busy = 1'b1;
        step("mem_busy_1", E_FREEZE);
        bus.ex_branch_taken = 1'b1;
        step("mem_busy_2_over_branch", E_WAIT);
        bus.ex_branch_taken = 1'b0;
        step("mem_busy_3", E_WAIT);
        bus.mem_busy = 1'b0;
        step("mem_wait_release", E_WAIT_REL);
        step("mem_wait_back_run", E_RUN);
        check_cnt("mem_busy_count");

        bus.id_halt = 1'b1;
        step("halt_issue", E_HALT_ISSUE);
        bus.id_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_busy = (i == 2);
            step("halted_idle", E_HALTED);
        end
        bus.mem_busy = 1'b0;
        bus.resume = 1'b1;
        step("resume", E_RESUME);
        bus.resume = 1'b0;
        step("after_resume_run", E_RUN);
        check_cnt("halt_count");

        bus.id_halt = 1'b1;
        step("halt_issue_2", E_HALT_ISSUE);
        bus.id_halt = 1'b0;
        step("halted_2a", E_HALTED);
        step("halted_2b", E_HALTED);
        #3;
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        exp_q.push_back(E_RESET); tag_q.push_back("async_reset_in_halt");
        check_outputs();
        check_cnt("async_reset_count");
        @(posedge clk); #1;
        reset = 1'b1;
        step("post_reset_run", E_RUN);

        bus.mem_busy = 1'b1;
        step("sat_busy_first", E_FREEZE);
        for (int i = 0; i < 17; i++)
            step("sat_busy", E_WAIT);
        check_cnt("stall_count_saturated");
        bus.mem_busy = 1'b0;
        step("sat_release", E_WAIT_REL);
        check_cnt("stall_count_held");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
